// File: rtl/imsic_csr_arbiter.sv
// Round-robin arbiter sharing one IMSIC CSR port among NR_REQ hart-side requesters.
// Each access runs IDLE (grant) -> ISSUE (drive IMSIC) -> RESP (return data).
module imsic_csr_arbiter #(
  parameter int unsigned NR_REQ  = 4,
  parameter int unsigned VGEIN_W = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NR_REQ-1:0]          i_req,
  output logic [NR_REQ-1:0]          o_gnt,
  input  logic [NR_REQ*2-1:0]        i_priv_lvl,
  input  logic [NR_REQ*VGEIN_W-1:0]  i_vgein,
  input  logic [NR_REQ*32-1:0]       i_addr,
  input  logic [NR_REQ*32-1:0]       i_wdata,
  input  logic [NR_REQ-1:0]          i_we,
  input  logic [NR_REQ-1:0]          i_claim,
  output logic [NR_REQ-1:0]          o_rvalid,
  output logic [31:0]                o_rdata,
  output logic                       o_err,
  output logic [NR_REQ-1:0]          o_imsic_sel,
  output logic [1:0]                 o_priv_lvl,
  output logic [VGEIN_W-1:0]         o_vgein,
  output logic [31:0]                o_imsic_addr,
  output logic [31:0]                o_imsic_data,
  output logic                       o_imsic_we,
  output logic                       o_imsic_claim,
  input  logic [31:0]                i_imsic_rdata
);

  localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NR_REQ-1:0]  sel_q;
  logic [1:0]         priv_q;
  logic [VGEIN_W-1:0] vgein_q;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic               we_q, claim_q, err_q;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx, cand_idx;
  int unsigned        cand;
  logic [NR_REQ-1:0]  gnt_oh;
  logic               grant;
  logic [1:0]         priv_sel;
  logic [VGEIN_W-1:0] vgein_sel;
  logic [31:0]        addr_sel, wdata_sel;
  logic               we_sel, claim_sel;
  logic               issue_ok;

  // Search starts at ptr_q and wraps, so the index after the last winner is favoured.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      cand     = (32'(ptr_q) + i) % NR_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && i_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    priv_sel  = '0;
    vgein_sel = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    claim_sel = 1'b0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        priv_sel  = i_priv_lvl[i*2 +: 2];
        vgein_sel = i_vgein[i*VGEIN_W +: VGEIN_W];
        addr_sel  = i_addr[i*32 +: 32];
        wdata_sel = i_wdata[i*32 +: 32];
        we_sel    = i_we[i];
        claim_sel = i_claim[i];
      end
    end
  end

  assign gnt_oh = win_found ? (NR_REQ'(1) << win_idx) : '0;
  assign grant  = (state_q == IDLE) && win_found;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
          ptr_d   = (win_idx == IDX_W'(NR_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      priv_q  <= '0;
      vgein_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      claim_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant) begin
        sel_q   <= gnt_oh;
        priv_q  <= priv_sel;
        // Guest file select only applies to supervisor-level accesses.
        vgein_q <= (priv_sel == 2'b01) ? vgein_sel : '0;
        addr_q  <= addr_sel;
        wdata_q <= wdata_sel;
        we_q    <= we_sel;
        claim_q <= claim_sel & ~we_sel;
        err_q   <= (priv_sel == 2'b10);
      end
      if (state_q == ISSUE) begin
        rdata_q <= err_q ? '0 : i_imsic_rdata;
      end
    end
  end

  assign issue_ok = (state_q == ISSUE) && !err_q;

  assign o_gnt         = ((state_q == IDLE) && !i_rst) ? gnt_oh : '0;
  assign o_imsic_sel   = issue_ok ? sel_q : '0;
  assign o_priv_lvl    = issue_ok ? priv_q : '0;
  assign o_vgein       = issue_ok ? vgein_q : '0;
  assign o_imsic_addr  = issue_ok ? addr_q : '0;
  assign o_imsic_data  = issue_ok ? wdata_q : '0;
  assign o_imsic_we    = issue_ok && we_q;
  assign o_imsic_claim = issue_ok && claim_q;
  assign o_rvalid      = (state_q == RESP) ? sel_q : '0;
  assign o_err         = (state_q == RESP) && err_q;
  assign o_rdata       = rdata_q;

endmodule
